// File: rtl/spi_peripheral_if.sv
//==============================================================================
// Module   : spi_peripheral_if
// Brief    : SPI pin bundle (sclk, copi, ncs) between an SPI controller and
//            the write-only register target.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface spi_peripheral_if;
   logic sclk;
   logic copi;
   logic ncs;

   modport master (output sclk, output copi, output ncs);
   modport slave  (input  sclk, input  copi, input  ncs);
endinterface

`default_nettype wire

// File: rtl/spi_peripheral.sv
//==============================================================================
// Module   : spi_peripheral
// Brief    : Write-only SPI mode-0 target driving five PWM control registers.
//            16-bit frames, committed at the nCS rising edge.
// Revision : 1.0
//==============================================================================
`default_nettype none

module spi_peripheral #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   spi_peripheral_if.slave      spi,
   output      logic [7:0]      en_reg_out_7_0,
   output      logic [7:0]      en_reg_out_15_8,
   output      logic [7:0]      en_reg_pwm_7_0,
   output      logic [7:0]      en_reg_pwm_15_8,
   output      logic [7:0]      pwm_duty_cycle,
   output      logic            frame_err
);

   localparam logic [4:0] c_FRAME_BITS = 5'd16;
   localparam logic [6:0] c_MAX_ADDR   = 7'h04;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHIFT   = 2'd1,
      S_OVERRUN = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic                   r_ncs_prev;
   logic                   r_sclk_prev;
   logic [SYNC_STAGES:0]   r_ncs_vld;

   logic                   w_ncs_s;
   logic                   w_sclk_s;
   logic                   w_copi_s;
   logic                   w_ncs_fall;
   logic                   w_ncs_rise;
   logic                   w_sclk_rise;

   state_t                 r_state;
   logic [4:0]             r_cnt;
   logic [15:0]            r_shift;
   logic [7:0]             r_out_lo;
   logic [7:0]             r_out_hi;
   logic [7:0]             r_pwm_lo;
   logic [7:0]             r_pwm_hi;
   logic [7:0]             r_duty;
   logic                   r_frame_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ncs_sync  <= '1;
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_prev  <= 1'b1;
         r_sclk_prev <= 1'b0;
         r_ncs_vld   <= '0;
      end else begin
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
         r_ncs_prev  <= r_ncs_sync[SYNC_STAGES-1];
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_ncs_vld   <= {r_ncs_vld[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];
   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s = r_copi_sync[SYNC_STAGES-1];

   // The ncs chain resets high, so a pin held low through reset would look like
   // a fall; only trust edges once the previous-value flop holds a real sample.
   assign w_ncs_fall  = r_ncs_prev & ~w_ncs_s & r_ncs_vld[SYNC_STAGES];
   assign w_ncs_rise  = ~r_ncs_prev & w_ncs_s;
   assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 5'd0;
         r_shift     <= 16'h0000;
         r_out_lo    <= 8'h00;
         r_out_hi    <= 8'h00;
         r_pwm_lo    <= 8'h00;
         r_pwm_hi    <= 8'h00;
         r_duty      <= 8'h00;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ncs_fall) begin
                  r_state <= S_SHIFT;
                  r_cnt   <= 5'd0;
                  r_shift <= 16'h0000;
               end
            end
            S_SHIFT: begin
               if (w_ncs_rise) begin
                  r_state <= S_IDLE;
                  if (r_cnt == c_FRAME_BITS) begin
                     // Reads and out-of-range addresses are silently dropped.
                     if (r_shift[15] && (r_shift[14:8] <= c_MAX_ADDR)) begin
                        case (r_shift[10:8])
                           3'd0:    r_out_lo <= r_shift[7:0];
                           3'd1:    r_out_hi <= r_shift[7:0];
                           3'd2:    r_pwm_lo <= r_shift[7:0];
                           3'd3:    r_pwm_hi <= r_shift[7:0];
                           default: r_duty   <= r_shift[7:0];
                        endcase
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else if (w_sclk_rise) begin
                  if (r_cnt == c_FRAME_BITS) begin
                     r_state <= S_OVERRUN;
                  end else begin
                     r_shift <= {r_shift[14:0], w_copi_s};
                     r_cnt   <= r_cnt + 5'd1;
                  end
               end
            end
            S_OVERRUN: begin
               if (w_ncs_rise) begin
                  r_state     <= S_IDLE;
                  r_frame_err <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign en_reg_out_7_0  = r_out_lo;
   assign en_reg_out_15_8 = r_out_hi;
   assign en_reg_pwm_7_0  = r_pwm_lo;
   assign en_reg_pwm_15_8 = r_pwm_hi;
   assign pwm_duty_cycle  = r_duty;
   assign frame_err       = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
//==============================================================================
// Module   : tb_spi_peripheral
// Brief    : Directed, table-driven bench for spi_peripheral.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_spi_peripheral;

   logic       clk;
   logic       rst_n;
   logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
   logic       frame_err;
   int         checks;
   int         errors;
   int         err_cnt;

   spi_peripheral_if spi ();

   spi_peripheral #(.SYNC_STAGES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .spi             (spi.slave),
      .en_reg_out_7_0  (out_lo),
      .en_reg_out_15_8 (out_hi),
      .en_reg_pwm_7_0  (pwm_lo),
      .en_reg_pwm_15_8 (pwm_hi),
      .pwm_duty_cycle  (duty),
      .frame_err       (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (frame_err) err_cnt++;

   typedef struct {
      string       name;
      logic [15:0] frame;
      int          nbits;
      logic [39:0] exp_regs;   // {duty, pwm_hi, pwm_lo, out_hi, out_lo}
      logic        exp_err;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [39:0] regs();
      return {duty, pwm_hi, pwm_lo, out_hi, out_lo};
   endfunction

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Bits beyond 16 are sent as 1.
   task automatic send_bits(input logic [15:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         spi.copi = (i < 16) ? f[15-i] : 1'b1;
         wait_clks(4);
         spi.sclk = 1'b1;
         wait_clks(4);
         spi.sclk = 1'b0;
      end
      wait_clks(4);
   endtask

   task automatic send_frame(input logic [15:0] f, input int nbits);
      spi.ncs = 1'b0;
      wait_clks(4);
      send_bits(f, nbits);
   endtask

   // Raise ncs, then check registers/frame_err on the 4 following clk edges:
   // old values on edges 1-2, new values from edge 3, err only on edge 3.
   task automatic finish_and_check(input string name, input logic [39:0] prev,
                                   input logic [39:0] exp, input logic exp_err);
      spi.ncs = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s regs@edge%0d", name, e), regs(), (e < 3) ? prev : exp);
         chk($sformatf("%s err@edge%0d", name, e), {39'd0, frame_err},
             {39'd0, (e == 3) ? exp_err : 1'b0});
      end
      wait_clks(4);
   endtask

   initial begin
      logic [39:0] prev;
      int          err_snap;

      checks  = 0;
      errors  = 0;
      err_cnt = 0;

      vecs[0] = '{"wr00",  16'h80FF, 16, 40'h00_00_00_00_FF, 1'b0};
      vecs[1] = '{"wr01",  16'h810F, 16, 40'h00_00_00_0F_FF, 1'b0};
      vecs[2] = '{"wr02",  16'h82AA, 16, 40'h00_00_AA_0F_FF, 1'b0};
      vecs[3] = '{"wr03",  16'h8355, 16, 40'h00_55_AA_0F_FF, 1'b0};
      vecs[4] = '{"wr04",  16'h8480, 16, 40'h80_55_AA_0F_FF, 1'b0};
      vecs[5] = '{"read",  16'h0412, 16, 40'h80_55_AA_0F_FF, 1'b0};
      vecs[6] = '{"badad", 16'h8533, 16, 40'h80_55_AA_0F_FF, 1'b0};
      vecs[7] = '{"short", 16'h80FF, 15, 40'h80_55_AA_0F_FF, 1'b1};
      vecs[8] = '{"long",  16'h82AA, 17, 40'h80_55_AA_0F_FF, 1'b1};
      vecs[9] = '{"rewr",  16'h8001, 16, 40'h80_55_AA_0F_01, 1'b0};

      spi.sclk = 1'b0;
      spi.copi = 1'b0;
      spi.ncs  = 1'b1;
      rst_n    = 1'b0;
      wait_clks(3);
      chk("reset regs", regs(), 40'd0);
      chk("reset err", {39'd0, frame_err}, 40'd0);
      rst_n = 1'b1;
      wait_clks(5);

      prev = 40'd0;
      for (int v = 0; v < 10; v++) begin
         send_frame(vecs[v].frame, vecs[v].nbits);
         finish_and_check(vecs[v].name, prev, vecs[v].exp_regs, vecs[v].exp_err);
         prev = vecs[v].exp_regs;
      end
      chk("err pulses after table", 40'(err_cnt), 40'd2);

      // Back-to-back frames with the minimum ncs high gap.
      err_snap = err_cnt;
      send_frame(16'h8410, 16);
      spi.ncs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b first duty", {32'd0, duty}, 40'h10);
      @(negedge clk);
      send_frame(16'h8420, 16);
      finish_and_check("b2b second", 40'h10_55_AA_0F_01, 40'h20_55_AA_0F_01, 1'b0);
      chk("b2b no err", 40'(err_cnt - err_snap), 40'd0);

      // Reset mid-frame, then a frame with ncs held low from reset.
      send_frame(16'h8377, 9);
      rst_n = 1'b0;
      #1;
      chk("async reset regs", regs(), 40'd0);
      wait_clks(3);
      rst_n = 1'b1;
      err_snap = err_cnt;
      wait_clks(4);
      send_bits(16'h8377, 16);
      spi.ncs = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("held-low frame no write", regs(), 40'd0);
      chk("held-low frame no err", 40'(err_cnt - err_snap), 40'd0);
      wait_clks(4);

      send_frame(16'h8377, 16);
      finish_and_check("post-reset wr03", 40'd0, 40'h00_77_00_00_00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
